// File: rtl/clint_dev.sv
// clint_dev: memory-mapped mtime / mtimecmp / msip / ctrl device driving machine timer and software interrupts.
// Optional build macro CLINT_PRESCALE_EN adds the ctrl[15:8] tick prescaler.
module clint_dev #(
  parameter logic [63:0] BASE_ADDR = 64'h2000_0000,
  parameter logic [63:0] MTIME_RST = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ren,
  input  logic        i_wen,
  input  logic [63:0] i_addr,
  input  logic [63:0] i_wdata,
  input  logic [7:0]  i_wstrb,
  output logic [63:0] o_rdata,
  output logic        o_read_ok,
  output logic        o_write_ok,
  output logic        o_mtip,
  output logic        o_msip
);

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    HOLD
  } state_t;

  localparam logic [8:0] IDX_MTIME    = 9'd0;
  localparam logic [8:0] IDX_MTIMECMP = 9'd1;
  localparam logic [8:0] IDX_MSIP     = 9'd2;
  localparam logic [8:0] IDX_CTRL     = 9'd3;

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic        do_write;
  logic        do_read;
  logic        in_window;
  logic [8:0]  reg_idx;
  logic        wr_mtime;
  logic        wr_mtimecmp;
  logic        wr_msip;
  logic        wr_ctrl;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic        cnt_en;
  logic        tick;
  logic [63:0] ctrl_val;
  logic [63:0] read_val;
  logic        unused_addr_bits;

  // Byte-lane merge: unstrobed lanes keep the register's current value.
  function automatic logic [63:0] merge_bytes(input logic [63:0] cur,
                                              input logic [63:0] wdata,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    res = cur;
    for (int unsigned i = 0; i < 8; i++) begin
      if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  assign unused_addr_bits = ^i_addr[2:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // HOLD waits for both request levels to drop so a held request is serviced once.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (i_ren || i_wen) begin
          accept     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: state_next = HOLD;
      HOLD: begin
        if (!i_ren && !i_wen) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign do_write    = accept & i_wen;
  assign do_read     = accept & ~i_wen;
  assign in_window   = (i_addr[63:12] == BASE_ADDR[63:12]);
  assign reg_idx     = i_addr[11:3];
  assign wr_mtime    = do_write & in_window & (reg_idx == IDX_MTIME);
  assign wr_mtimecmp = do_write & in_window & (reg_idx == IDX_MTIMECMP);
  assign wr_msip     = do_write & in_window & (reg_idx == IDX_MSIP);
  assign wr_ctrl     = do_write & in_window & (reg_idx == IDX_CTRL);

`ifdef CLINT_PRESCALE_EN
  logic [7:0] prescale;
  logic [7:0] presc_cnt;

  assign tick     = cnt_en && (presc_cnt == prescale);
  assign ctrl_val = {48'b0, prescale, 7'b0, cnt_en};

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale  <= '0;
      presc_cnt <= '0;
    end else begin
      if (wr_ctrl && i_wstrb[1]) prescale <= i_wdata[15:8];
      if (wr_ctrl)               presc_cnt <= '0;
      else if (tick)             presc_cnt <= '0;
      else if (cnt_en)           presc_cnt <= presc_cnt + 8'd1;
    end
  end
`else
  assign tick     = cnt_en;
  assign ctrl_val = {63'b0, cnt_en};
`endif

  // A write to mtime takes priority over that cycle's increment.
  always_ff @(posedge clk) begin
    if (rst)           mtime <= MTIME_RST;
    else if (wr_mtime) mtime <= merge_bytes(mtime, i_wdata, i_wstrb);
    else if (tick)     mtime <= mtime + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)              mtimecmp <= '1;
    else if (wr_mtimecmp) mtimecmp <= merge_bytes(mtimecmp, i_wdata, i_wstrb);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msip   <= 1'b0;
      cnt_en <= 1'b1;
    end else begin
      if (wr_msip && i_wstrb[0]) msip   <= i_wdata[0];
      if (wr_ctrl && i_wstrb[0]) cnt_en <= i_wdata[0];
    end
  end

  always_comb begin
    read_val = '0;
    if (in_window) begin
      case (reg_idx)
        IDX_MTIME:    read_val = mtime;
        IDX_MTIMECMP: read_val = mtimecmp;
        IDX_MSIP:     read_val = {63'b0, msip};
        IDX_CTRL:     read_val = ctrl_val;
        default:      read_val = '0;
      endcase
    end
  end

  // Response is registered at the sampling edge, so read data is the pre-increment snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rdata    <= '0;
      o_read_ok  <= 1'b0;
      o_write_ok <= 1'b0;
      o_mtip     <= 1'b0;
      o_msip     <= 1'b0;
    end else begin
      o_rdata    <= do_read ? read_val : '0;
      o_read_ok  <= do_read;
      o_write_ok <= do_write;
      o_mtip     <= (mtime >= mtimecmp);
      o_msip     <= msip;
    end
  end

endmodule

// File: tb/tb_clint_dev.sv
// Directed self-checking bench for clint_dev: register map, handshake, timer/soft interrupts, wrap, prescale.
module tb_clint_dev;

  logic        clk;
  logic        rst;
  logic        ren;
  logic        wen;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic [63:0] rdata;
  logic        read_ok;
  logic        write_ok;
  logic        mtip;
  logic        msip;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int r_edge = 0;

  localparam logic [63:0] A_MTIME    = 64'h2000_0000;
  localparam logic [63:0] A_MTIMECMP = 64'h2000_0008;
  localparam logic [63:0] A_MSIP     = 64'h2000_0010;
  localparam logic [63:0] A_CTRL     = 64'h2000_0018;

  clint_dev #(
    .BASE_ADDR(64'h2000_0000),
    .MTIME_RST(64'h0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_ren     (ren),
    .i_wen     (wen),
    .i_addr    (addr),
    .i_wdata   (wdata),
    .i_wstrb   (wstrb),
    .o_rdata   (rdata),
    .o_read_ok (read_ok),
    .o_write_ok(write_ok),
    .o_mtip    (mtip),
    .o_msip    (msip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Called #1 after an edge with the DUT idle; n is the edge that sampled the request.
  task automatic bus_xfer(input logic r, input logic w, input logic [63:0] a,
                          input logic [63:0] d, input logic [7:0] s,
                          output logic ok_r, output logic ok_w,
                          output logic [63:0] rd, output int n);
    ren = r; wen = w; addr = a; wdata = d; wstrb = s;
    @(posedge clk); #1;
    ok_r = read_ok; ok_w = write_ok; rd = rdata; n = cyc;
    ren = 1'b0; wen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                        output logic ok, output int n);
    logic okr;
    logic [63:0] rd;
    bus_xfer(1'b0, 1'b1, a, d, s, okr, ok, rd, n);
  endtask

  task automatic bus_rd(input logic [63:0] a, output logic ok, output logic [63:0] rd, output int n);
    logic okw;
    bus_xfer(1'b1, 1'b0, a, 64'h0, 8'h00, ok, okw, rd, n);
  endtask

  task automatic test_reset;
    logic ok;
    logic [63:0] v1, v2;
    int n1, n2;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({read_ok, write_ok, mtip, msip} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 0000", {read_ok, write_ok, mtip, msip});
    end
    n_cmp++;
    if (rdata !== 64'h0) begin
      n_bad++; $display("FAIL reset_rdata: got %h expected 0", rdata);
    end
    rst = 1'b0;
    r_edge = cyc;
    bus_rd(A_MTIME, ok, v1, n1);
    n_cmp++;
    if (ok !== 1'b1 || v1 !== 64'(n1 - r_edge - 1)) begin
      n_bad++; $display("FAIL mtime_first: ok %b got %h expected %h", ok, v1, 64'(n1 - r_edge - 1));
    end
    repeat (5) @(posedge clk);
    #1;
    bus_rd(A_MTIME, ok, v2, n2);
    n_cmp++;
    if (v2 - v1 !== 64'(n2 - n1)) begin
      n_bad++; $display("FAIL mtime_delta: got %0d expected %0d", v2 - v1, n2 - n1);
    end
    bus_rd(A_MTIMECMP, ok, v1, n1);
    n_cmp++;
    if (v1 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_bad++; $display("FAIL mtimecmp_reset: got %h expected ffffffffffffffff", v1);
    end
    bus_rd(A_CTRL, ok, v1, n1);
    n_cmp++;
    if (v1 !== 64'h1) begin
      n_bad++; $display("FAIL ctrl_reset: got %h expected 1", v1);
    end
    n_cmp++;
    if (mtip !== 1'b0) begin
      n_bad++; $display("FAIL mtip_reset: got %b expected 0", mtip);
    end
  endtask

  task automatic test_timer_irq;
    logic ok;
    int w, c;
    bus_wr(A_MTIMECMP, 64'd20, 8'hFF, ok, c);
    bus_wr(A_MTIME, 64'd15, 8'hFF, ok, w);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++; $display("FAIL mtime_write_ok: got %b expected 1", ok);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (mtip !== 1'b0 || cyc != w + 5) begin
      n_bad++; $display("FAIL mtip_early: got %b at +%0d expected 0 at +5", mtip, cyc - w);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (mtip !== 1'b1) begin
      n_bad++; $display("FAIL mtip_rise: got %b expected 1", mtip);
    end
    bus_wr(A_MTIMECMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, ok, c);
    n_cmp++;
    if (mtip !== 1'b0) begin
      n_bad++; $display("FAIL mtip_clear: got %b expected 0", mtip);
    end
  endtask

  task automatic test_wrap_and_strobe;
    logic ok;
    logic [63:0] v;
    int n, c;
    bus_wr(A_CTRL, 64'h0, 8'hFF, ok, n);
    bus_wr(A_MTIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, ok, n);
    bus_rd(A_MTIME, ok, v, n);
    n_cmp++;
    if (v !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      n_bad++; $display("FAIL mtime_stopped: got %h expected fffffffffffffffe", v);
    end
    bus_wr(A_MTIME, 64'h0000_0000_0000_0012, 8'h01, ok, n);
    bus_rd(A_MTIME, ok, v, n);
    n_cmp++;
    if (v !== 64'hFFFF_FFFF_FFFF_FF12) begin
      n_bad++; $display("FAIL mtime_strobe: got %h expected ffffffffffffff12", v);
    end
    bus_wr(A_MTIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, ok, n);
    bus_wr(A_CTRL, 64'h1, 8'hFF, ok, c);
    for (int k = 0; k < 2; k++) begin
      bus_rd(A_MTIME, ok, v, n);
      n_cmp++;
      if (v !== 64'hFFFF_FFFF_FFFF_FFFE + 64'(n - c - 1)) begin
        n_bad++; $display("FAIL mtime_wrap%0d: got %h expected %h", k, v,
                          64'hFFFF_FFFF_FFFF_FFFE + 64'(n - c - 1));
      end
    end
  endtask

  task automatic test_ctrl_prescale;
    logic ok;
    logic [63:0] v;
    logic [63:0] exp;
    int n, c;
    bus_wr(A_CTRL, 64'h0, 8'hFF, ok, n);
    bus_wr(A_MTIME, 64'h0, 8'hFF, ok, n);
    bus_wr(A_CTRL, 64'h0301, 8'hFF, ok, c);
    bus_rd(A_CTRL, ok, v, n);
`ifdef CLINT_PRESCALE_EN
    exp = 64'h0301;
`else
    exp = 64'h1;
`endif
    n_cmp++;
    if (v !== exp) begin
      n_bad++; $display("FAIL ctrl_readback: got %h expected %h", v, exp);
    end
    for (int k = 0; k < 3; k++) begin
      bus_rd(A_MTIME, ok, v, n);
`ifdef CLINT_PRESCALE_EN
      exp = 64'((n - c - 1) / 4);
`else
      exp = 64'(n - c - 1);
`endif
      n_cmp++;
      if (v !== exp) begin
        n_bad++; $display("FAIL mtime_rate%0d: got %h expected %h", k, v, exp);
      end
      @(posedge clk); #1;
    end
    bus_wr(A_CTRL, 64'h1, 8'hFF, ok, n);
  endtask

  task automatic test_held_request;
    int pulses = 0;
    int first = -1;
    int stray = 0;
    logic ok;
    logic [63:0] v;
    int n;
    ren = 1'b1; addr = A_MSIP;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (read_ok === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end else if (rdata !== 64'h0) begin
        stray++;
      end
    end
    n_cmp++;
    if (pulses != 1 || first != 0) begin
      n_bad++; $display("FAIL held_ren: got %0d pulses first %0d expected 1 pulse first 0", pulses, first);
    end
    n_cmp++;
    if (stray != 0) begin
      n_bad++; $display("FAIL rdata_idle: got %0d nonzero cycles expected 0", stray);
    end
    ren = 1'b0;
    @(posedge clk); #1;
    bus_rd(A_MSIP, ok, v, n);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++; $display("FAIL after_hold: got ok %b expected 1", ok);
    end
  endtask

  task automatic test_msip;
    logic ok, okr, okw;
    logic [63:0] v;
    int n;
    bus_wr(A_MSIP, 64'hFF, 8'h01, ok, n);
    n_cmp++;
    if (ok !== 1'b1 || msip !== 1'b1) begin
      n_bad++; $display("FAIL msip_set: got ok %b msip %b expected 1 1", ok, msip);
    end
    bus_wr(A_MSIP, 64'h0, 8'h00, ok, n);
    n_cmp++;
    if (msip !== 1'b1) begin
      n_bad++; $display("FAIL msip_nostrb: got %b expected 1", msip);
    end
    bus_rd(A_MSIP, ok, v, n);
    n_cmp++;
    if (v !== 64'h1) begin
      n_bad++; $display("FAIL msip_read: got %h expected 1", v);
    end
    bus_xfer(1'b1, 1'b1, A_MSIP, 64'h0, 8'hFF, okr, okw, v, n);
    n_cmp++;
    if ({okr, okw, msip} !== 3'b010 || v !== 64'h0) begin
      n_bad++; $display("FAIL ren_wen: got r%b w%b msip%b rdata %h expected r0 w1 msip0 rdata 0",
                        okr, okw, msip, v);
    end
  endtask

  task automatic test_unmapped;
    logic ok;
    logic [63:0] v;
    int n;
    bus_wr(64'h3000_0010, 64'h1, 8'hFF, ok, n);
    n_cmp++;
    if (ok !== 1'b1 || msip !== 1'b0) begin
      n_bad++; $display("FAIL outwin_write: got ok %b msip %b expected 1 0", ok, msip);
    end
    bus_rd(64'h2000_0020, ok, v, n);
    n_cmp++;
    if (ok !== 1'b1 || v !== 64'h0) begin
      n_bad++; $display("FAIL unmapped_read: got ok %b data %h expected 1 0", ok, v);
    end
    bus_rd(64'h3000_0000, ok, v, n);
    n_cmp++;
    if (ok !== 1'b1 || v !== 64'h0) begin
      n_bad++; $display("FAIL outwin_read: got ok %b data %h expected 1 0", ok, v);
    end
    bus_rd(64'h2000_000C, ok, v, n);
    n_cmp++;
    if (v !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_bad++; $display("FAIL low_bits_ignored: got %h expected ffffffffffffffff", v);
    end
  endtask

  task automatic test_reset_mid_resp;
    logic ok;
    logic [63:0] v;
    int n;
    bus_wr(A_MTIMECMP, 64'd5, 8'hFF, ok, n);
    ren = 1'b1; addr = A_MTIME;
    @(posedge clk); #1;
    n_cmp++;
    if (read_ok !== 1'b1) begin
      n_bad++; $display("FAIL resp_before_rst: got %b expected 1", read_ok);
    end
    rst = 1'b1; ren = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (read_ok !== 1'b0 || rdata !== 64'h0) begin
      n_bad++; $display("FAIL rst_in_resp: got ok %b data %h expected 0 0", read_ok, rdata);
    end
    rst = 1'b0;
    bus_rd(A_MTIMECMP, ok, v, n);
    n_cmp++;
    if (ok !== 1'b1 || v !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_bad++; $display("FAIL post_rst_read: got ok %b data %h expected 1 ffffffffffffffff", ok, v);
    end
  endtask

  initial begin
    rst = 1'b1; ren = 1'b0; wen = 1'b0;
    addr = '0; wdata = '0; wstrb = '0;
    test_reset();
    test_timer_irq();
    test_wrap_and_strobe();
    test_ctrl_prescale();
    test_held_request();
    test_msip();
    test_unmapped();
    test_reset_mid_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
